led_sweep_ctrl: RTL and testbench

- Sequencer that drives the enable and select inputs of the 4-to-16 binary decoder (four_16bin_decoder), so the 16 LED outputs light one at a time in a programmable pattern.
- Contains a tick prescaler that sets the step rate, and a small FSM that runs the selected sweep mode and handles start/stop.
- Sits between the board-level button/switch logic and the decoder instance.

---
 rtl/led_sweep_pkg.sv | 23 ++
 rtl/led_sweep_ctrl_if.sv | 34 +++
 rtl/four_16bin_decoder.sv | 17 +
 rtl/led_sweep_ctrl_tick_prescaler.sv | 32 +++
 rtl/led_sweep_ctrl.sv | 126 ++++++++++++
 tb/tb_led_sweep_ctrl.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/led_sweep_pkg.sv
// Shared types and constants for the LED sweep sequencer.
// Mode codes, FSM state and LED index width.
package led_sweep_pkg;

    localparam int          LED_IDX_W = 4;
    localparam logic [3:0]  LED_MAX   = 4'd15;

    localparam logic [1:0]  MODE_UP   = 2'b00;
    localparam logic [1:0]  MODE_DOWN = 2'b01;
    localparam logic [1:0]  MODE_PING = 2'b10;
    localparam logic [1:0]  MODE_ONCE = 2'b11;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

endpackage

// File: rtl/led_sweep_ctrl_if.sv
// Control/status bundle between board logic and the sweep sequencer.
// master = board side (drives start/stop/mode), slave = sequencer.
interface led_sweep_ctrl_if;
    import led_sweep_pkg::*;

    logic                 start;
    logic                 stop;
    logic [1:0]           mode;
    logic                 en;
    logic [LED_IDX_W-1:0] a;
    logic                 busy;
    logic                 wrap;

    modport master (
        output start,
        output stop,
        output mode,
        input  en,
        input  a,
        input  busy,
        input  wrap
    );

    modport slave (
        input  start,
        input  stop,
        input  mode,
        output en,
        output a,
        output busy,
        output wrap
    );

endinterface

// File: rtl/four_16bin_decoder.sv
// 4-to-16 one-hot decoder with active-high enable.
// Board-side consumer of the sweep sequencer outputs.
module four_16bin_decoder (
    input  logic        i_en,
    input  logic [3:0]  i_sel,
    output logic [15:0] o_y
);

    // One-hot decode of the select when enabled, all dark otherwise.
    always_comb begin
        o_y = '0;
        if (i_en) begin
            o_y[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/led_sweep_ctrl_tick_prescaler.sv
// Step-rate prescaler: one-cycle tick every TICK_DIV cycles.
// clr holds the count at zero so a fresh run starts a full period.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign tick   = !clr && w_last;

    // Count 0..TICK_DIV-1 and roll over; clr or rst parks it at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_sweep_ctrl.sv
// LED sweep sequencer: steps the decoder select through
// up/down/ping-pong/one-shot patterns at a prescaled rate.
module led_sweep_ctrl
    import led_sweep_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    led_sweep_ctrl_if.slave     bus,
    output logic [15:0]         o_led
);

    state_t               r_state;
    dir_t                 r_dir;
    logic [1:0]           r_mode_q;
    logic                 r_en;
    logic [LED_IDX_W-1:0] r_a;
    logic                 r_busy;
    logic                 r_wrap;

    logic                 w_clr;
    logic                 w_tick;

    assign w_clr = (r_state != RUN) || bus.stop;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Sequencer FSM with all outputs registered; stop beats a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dir    <= DIR_UP;
            r_mode_q <= MODE_UP;
            r_en     <= 1'b0;
            r_a      <= '0;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_en   <= 1'b0;
                    r_busy <= 1'b0;
                    r_a    <= '0;
                    if (bus.start && !bus.stop) begin
                        r_state  <= RUN;
                        r_en     <= 1'b1;
                        r_busy   <= 1'b1;
                        r_mode_q <= bus.mode;
                        r_dir    <= DIR_UP;
                        r_a      <= (bus.mode == MODE_DOWN) ? LED_MAX : '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_a     <= '0;
                    end else if (w_tick) begin
                        unique case (r_mode_q)
                            MODE_UP: begin
                                r_a    <= r_a + 4'd1;
                                r_wrap <= (r_a == LED_MAX);
                            end
                            MODE_DOWN: begin
                                r_a    <= r_a - 4'd1;
                                r_wrap <= (r_a == '0);
                            end
                            MODE_PING: begin
                                if (r_dir == DIR_UP) begin
                                    if (r_a == LED_MAX) begin
                                        r_a    <= LED_MAX - 4'd1;
                                        r_dir  <= DIR_DOWN;
                                        r_wrap <= 1'b1;
                                    end else begin
                                        r_a <= r_a + 4'd1;
                                    end
                                end else begin
                                    if (r_a == '0) begin
                                        r_a    <= 4'd1;
                                        r_dir  <= DIR_UP;
                                        r_wrap <= 1'b1;
                                    end else begin
                                        r_a <= r_a - 4'd1;
                                    end
                                end
                            end
                            MODE_ONCE: begin
                                if (r_a == LED_MAX) begin
                                    r_state <= IDLE;
                                    r_en    <= 1'b0;
                                    r_busy  <= 1'b0;
                                    r_a     <= '0;
                                    r_wrap  <= 1'b1;
                                end else begin
                                    r_a <= r_a + 4'd1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.en   = r_en;
    assign bus.a    = r_a;
    assign bus.busy = r_busy;
    assign bus.wrap = r_wrap;

    four_16bin_decoder u_decoder (
        .i_en  (r_en),
        .i_sel (r_a),
        .o_y   (o_led)
    );

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Bench for led_sweep_ctrl: TICK_DIV=4 and TICK_DIV=1 instances
// share stimulus and are checked against a pattern-level model.
module tb_led_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_start;
    logic       t_stop;
    logic [1:0] t_mode;
    logic [15:0] led4;
    logic [15:0] led1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_sweep_ctrl_if if4 ();
    led_sweep_ctrl_if if1 ();

    assign if4.start = t_start;
    assign if4.stop  = t_stop;
    assign if4.mode  = t_mode;
    assign if1.start = t_start;
    assign if1.stop  = t_stop;
    assign if1.mode  = t_mode;

    led_sweep_ctrl #(.TICK_DIV(4)) u4 (
        .clk   (clk),
        .rst   (rst),
        .bus   (if4.slave),
        .o_led (led4)
    );

    led_sweep_ctrl #(.TICK_DIV(1)) u1 (
        .clk   (clk),
        .rst   (rst),
        .bus   (if1.slave),
        .o_led (led1)
    );

    // Model: a run is a count c of cycles since start; step k = c/TD.
    bit         mvalid = 1'b0;
    bit         m_run [2];
    logic [1:0] m_mq  [2];
    int         m_c   [2];
    logic [6:0] m_ev  [2];
    int         m_k;
    logic [3:0] m_na;
    logic       m_nw;

    function automatic int tdv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // LED index and wrap flag after step k (k >= 1) of a pattern.
    function automatic void pat(input logic [1:0] md, input int k,
                                output logic [3:0] a, output logic w);
        int p;
        case (md)
            2'b00: begin a = 4'(k % 16);      w = (k % 16 == 0); end
            2'b01: begin a = 4'(15 - k % 16); w = (k % 16 == 0); end
            2'b10: begin
                p = k % 30;
                a = (p <= 15) ? 4'(p) : 4'(30 - p);
                w = (p == 16) || (p == 1 && k > 1);
            end
            default: begin a = 4'(k % 16); w = 1'b0; end
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] = 1'b0;
                m_c[i]   = 0;
                m_ev[i]  = 7'b0;
                mvalid   = 1'b1;
            end else if (!m_run[i]) begin
                if (t_start && !t_stop) begin
                    m_run[i] = 1'b1;
                    m_mq[i]  = t_mode;
                    m_c[i]   = 0;
                    m_ev[i]  = {1'b1, (t_mode == 2'b01) ? 4'd15 : 4'd0,
                                1'b1, 1'b0};
                end else begin
                    m_ev[i] = 7'b0;
                end
            end else if (t_stop) begin
                m_run[i] = 1'b0;
                m_ev[i]  = 7'b0;
            end else begin
                m_c[i] = m_c[i] + 1;
                if (m_c[i] % tdv(i) == 0) begin
                    m_k = m_c[i] / tdv(i);
                    if (m_mq[i] == 2'b11 && m_k == 16) begin
                        m_run[i] = 1'b0;
                        m_ev[i]  = 7'b0000001;
                    end else begin
                        pat(m_mq[i], m_k, m_na, m_nw);
                        m_ev[i] = {1'b1, m_na, 1'b1, m_nw};
                    end
                end else begin
                    m_ev[i][0] = 1'b0;
                end
            end
        end
    end

    function automatic logic [6:0] g4();
        return {if4.en, if4.a, if4.busy, if4.wrap};
    endfunction

    function automatic logic [6:0] g1();
        return {if1.en, if1.a, if1.busy, if1.wrap};
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                logic [6:0] got;
                got = (i == 0) ? g4() : g1();
                checks++;
                if (got !== m_ev[i]) begin
                    failures++;
                    $display("FAIL model_td%0d t=%0t got{en,a,busy,wrap}=%b exp=%b",
                             tdv(i), $time, got, m_ev[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got{en,a,busy,wrap}=%b exp=%b",
                     name, $time, got, exp);
        end
    endtask

    task automatic go(input logic [1:0] m);
        @(negedge clk);
        t_start = 1'b1;
        t_mode  = m;
        @(negedge clk);
        t_start = 1'b0;
    endtask

    task automatic wait_e(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_stop();
        @(negedge clk);
        t_stop = 1'b1;
        @(negedge clk);
        t_stop = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        t_start = 1'b0;
        t_stop  = 1'b0;
        t_mode  = 2'b00;
        wait_e(2);
        chk("reset_state", g4(), 7'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a run, then restart.
        go(2'b00);
        wait_e(28);
        chk("pre_rst_a7", g4(), {1'b1, 4'd7, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_run", g4(), 7'b0);
        go(2'b00);
        chk("start_after_rst", g4(), {1'b1, 4'd0, 1'b1, 1'b0});
        do_stop();

        // Up mode.
        go(2'b00);
        wait_e(5);
        chk("up_a1", g4(), {1'b1, 4'd1, 1'b1, 1'b0});
        chk("up_td1_a5", g1(), {1'b1, 4'd5, 1'b1, 1'b0});
        wait_e(59);
        chk("up_wrap", g4(), {1'b1, 4'd0, 1'b1, 1'b1});
        do_stop();
        chk("stop_idle", g4(), 7'b0);

        // Down mode with a mid-run mode change.
        go(2'b01);
        chk("down_first", g4(), {1'b1, 4'd15, 1'b1, 1'b0});
        @(negedge clk);
        t_mode = 2'b00;
        wait_e(63);
        chk("down_wrap", g4(), {1'b1, 4'd15, 1'b1, 1'b1});
        do_stop();

        // Ping-pong.
        go(2'b10);
        wait_e(60);
        chk("ping_15", g4(), {1'b1, 4'd15, 1'b1, 1'b0});
        wait_e(3);
        chk("ping_15_hold", g4(), {1'b1, 4'd15, 1'b1, 1'b0});
        wait_e(1);
        chk("ping_turn_dn", g4(), {1'b1, 4'd14, 1'b1, 1'b1});
        wait_e(56);
        chk("ping_0", g4(), {1'b1, 4'd0, 1'b1, 1'b0});
        wait_e(4);
        chk("ping_turn_up", g4(), {1'b1, 4'd1, 1'b1, 1'b1});
        do_stop();

        // One-shot with start held across completion.
        @(negedge clk);
        t_start = 1'b1;
        t_mode  = 2'b11;
        wait_e(65);
        chk("once_end", g4(), 7'b0000001);
        wait_e(1);
        chk("once_restart", g4(), {1'b1, 4'd0, 1'b1, 1'b0});
        @(negedge clk);
        t_start = 1'b0;
        do_stop();

        // Stop coincident with a step.
        go(2'b00);
        repeat (3) @(posedge clk);
        do_stop();
        chk("stop_on_step", g4(), 7'b0);

        // start and stop together in IDLE.
        @(negedge clk);
        t_start = 1'b1;
        t_stop  = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        t_stop  = 1'b0;
        chk("start_stop_idle", g4(), 7'b0);

        // Randomized traffic.
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 1999) == 0);
            t_start = ($urandom_range(0, 7) == 0);
            t_stop  = ($urandom_range(0, 79) == 0);
            t_mode  = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst     = 1'b0;
        t_start = 1'b0;
        t_stop  = 1'b0;
        wait_e(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
